// File: rtl/lsu_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_pkg: shared types and page map for the store/load unit path    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  localparam logic [19:0] PG_LEDR  = 20'h10000;
  localparam logic [19:0] PG_LEDG  = 20'h10001;
  localparam logic [19:0] PG_HEXLO = 20'h10002;
  localparam logic [19:0] PG_HEXHI = 20'h10003;
  localparam logic [19:0] PG_LCD   = 20'h10004;

  typedef enum logic [2:0] {
    REG_DMEM  = 3'd0,
    REG_LEDR  = 3'd1,
    REG_LEDG  = 3'd2,
    REG_HEXLO = 3'd3,
    REG_HEXHI = 3'd4,
    REG_LCD   = 3'd5,
    REG_NONE  = 3'd6
  } region_e;

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[i*8 +: 8] = be[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_lane_align.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_lane_align: size/offset to byte enables, lane data, alignment  |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  always_comb begin
    be         = 4'b0000;
    wdata      = data;
    misaligned = 1'b0;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{data[7:0]}};
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{data[15:0]}};
        misaligned = addr_lo[0];
      end
      SZ_WORD: begin
        be         = 4'b1111;
        misaligned = |addr_lo;
      end
      // reserved size is rejected upstream; no lanes enabled
      default: be = 4'b0000;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/lsu_store_demux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | lsu_store_demux: store steering to DMEM or memory-mapped outputs    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module lsu_store_demux
  import lsu_pkg::*;
#(
  parameter int DMEM_AW   = 11,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic [31:0]          i_lsu_addr,
  input  logic [31:0]          i_st_data,
  input  logic                 i_lsu_wren,
  input  logic [1:0]           i_st_size,
  output logic                 o_dmem_we,
  output logic [3:0]           o_dmem_be,
  output logic [31:0]          o_dmem_wdata,
  output logic [16:0]          o_io_ledr,
  output logic [7:0]           o_io_ledg,
  output logic [6:0]           o_io_hex0,
  output logic [6:0]           o_io_hex1,
  output logic [6:0]           o_io_hex2,
  output logic [6:0]           o_io_hex3,
  output logic [6:0]           o_io_hex4,
  output logic [6:0]           o_io_hex5,
  output logic [6:0]           o_io_hex6,
  output logic [6:0]           o_io_hex7,
  output logic [31:0]          o_io_lcd,
  output logic [31:0]          o_io_rdata,
  output logic                 o_st_err,
  output logic [ERR_CNT_W-1:0] o_err_cnt
);

  size_e       size;
  region_e     region;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        misaligned;
  logic        accept;
  logic        reject;
  logic        io_we;

  logic [31:0] ledr_q, ledg_q, hexlo_q, hexhi_q, lcd_q;
  logic        st_err_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign size = size_e'(i_st_size);

  lsu_lane_align u_align (
    .size       (size),
    .addr_lo    (i_lsu_addr[1:0]),
    .data       (i_st_data),
    .be         (be),
    .wdata      (wdata),
    .misaligned (misaligned)
  );

  // output pages only decode at offset 0..3 of their 4 KiB page
  always_comb begin
    region = REG_NONE;
    if (i_lsu_addr[31:DMEM_AW] == '0) begin
      region = REG_DMEM;
    end else if (i_lsu_addr[11:2] == 10'd0) begin
      case (i_lsu_addr[31:12])
        PG_LEDR:  region = REG_LEDR;
        PG_LEDG:  region = REG_LEDG;
        PG_HEXLO: region = REG_HEXLO;
        PG_HEXHI: region = REG_HEXHI;
        PG_LCD:   region = REG_LCD;
        default:  region = REG_NONE;
      endcase
    end
  end

  assign accept = i_lsu_wren && (size != SZ_RSVD) && !misaligned && (region != REG_NONE);
  assign reject = i_lsu_wren && !accept;
  assign io_we  = accept && (region != REG_DMEM);

  assign o_dmem_we    = accept && (region == REG_DMEM);
  assign o_dmem_be    = be;
  assign o_dmem_wdata = wdata;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ledr_q  <= '0;
      ledg_q  <= '0;
      hexlo_q <= '0;
      hexhi_q <= '0;
      lcd_q   <= '0;
    end else if (io_we) begin
      case (region)
        REG_LEDR:  ledr_q  <= merge_bytes(ledr_q,  wdata, be);
        REG_LEDG:  ledg_q  <= merge_bytes(ledg_q,  wdata, be);
        REG_HEXLO: hexlo_q <= merge_bytes(hexlo_q, wdata, be);
        REG_HEXHI: hexhi_q <= merge_bytes(hexhi_q, wdata, be);
        REG_LCD:   lcd_q   <= merge_bytes(lcd_q,   wdata, be);
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      st_err_q  <= 1'b0;
      err_cnt_q <= '0;
    end else begin
      st_err_q <= reject;
      if (reject && (err_cnt_q != '1)) begin
        err_cnt_q <= err_cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    case (region)
      REG_LEDR:  o_io_rdata = ledr_q;
      REG_LEDG:  o_io_rdata = ledg_q;
      REG_HEXLO: o_io_rdata = hexlo_q;
      REG_HEXHI: o_io_rdata = hexhi_q;
      REG_LCD:   o_io_rdata = lcd_q;
      default:   o_io_rdata = 32'd0;
    endcase
  end

  assign o_io_ledr = ledr_q[16:0];
  assign o_io_ledg = ledg_q[7:0];
  assign o_io_hex0 = hexlo_q[6:0];
  assign o_io_hex1 = hexlo_q[14:8];
  assign o_io_hex2 = hexlo_q[22:16];
  assign o_io_hex3 = hexlo_q[30:24];
  assign o_io_hex4 = hexhi_q[6:0];
  assign o_io_hex5 = hexhi_q[14:8];
  assign o_io_hex6 = hexhi_q[22:16];
  assign o_io_hex7 = hexhi_q[30:24];
  assign o_io_lcd  = lcd_q;
  assign o_st_err  = st_err_q;
  assign o_err_cnt = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu_store_demux.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_lsu_store_demux: directed vector table plus multi-cycle cases   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_lsu_store_demux;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] addr;
  logic [31:0] data;
  logic        wren;
  logic [1:0]  size;
  logic        dmem_we;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [16:0] ledr;
  logic [7:0]  ledg;
  logic [6:0]  hex [8];
  logic [31:0] lcd;
  logic [31:0] rdata;
  logic        st_err;
  logic [7:0]  err_cnt;

  int passed = 0;
  int total  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  lsu_store_demux #(.DMEM_AW(11), .ERR_CNT_W(8)) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_lsu_addr   (addr),
    .i_st_data    (data),
    .i_lsu_wren   (wren),
    .i_st_size    (size),
    .o_dmem_we    (dmem_we),
    .o_dmem_be    (dmem_be),
    .o_dmem_wdata (dmem_wdata),
    .o_io_ledr    (ledr),
    .o_io_ledg    (ledg),
    .o_io_hex0    (hex[0]),
    .o_io_hex1    (hex[1]),
    .o_io_hex2    (hex[2]),
    .o_io_hex3    (hex[3]),
    .o_io_hex4    (hex[4]),
    .o_io_hex5    (hex[5]),
    .o_io_hex6    (hex[6]),
    .o_io_hex7    (hex[7]),
    .o_io_lcd     (lcd),
    .o_io_rdata   (rdata),
    .o_st_err     (st_err),
    .o_err_cnt    (err_cnt)
  );

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic        wren;
    logic [1:0]  size;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
  endtask

  task automatic drive(input logic [31:0] a, input logic [31:0] d,
                       input logic w, input logic [1:0] s);
    addr = a; data = d; wren = w; size = s;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // addr, data, wren, size, exp_we, exp_be, exp_wdata, exp_err
    vecs[0] = '{32'h0000_0010, 32'hDEAD_BEEF, 1'b1, 2'b10, 1'b1, 4'b1111, 32'hDEAD_BEEF, 1'b0};
    vecs[1] = '{32'h0000_0013, 32'h0000_00AB, 1'b1, 2'b00, 1'b1, 4'b1000, 32'hABAB_ABAB, 1'b0};
    vecs[2] = '{32'h0000_0021, 32'h1234_5678, 1'b1, 2'b00, 1'b1, 4'b0010, 32'h7878_7878, 1'b0};
    vecs[3] = '{32'h0000_0022, 32'h0000_BEEF, 1'b1, 2'b01, 1'b1, 4'b1100, 32'hBEEF_BEEF, 1'b0};
    vecs[4] = '{32'h0000_07FC, 32'h1122_3344, 1'b1, 2'b10, 1'b1, 4'b1111, 32'h1122_3344, 1'b0};
    vecs[5] = '{32'h0000_0800, 32'h1122_3344, 1'b1, 2'b10, 1'b0, 4'b0000, 32'h0,         1'b1};
    vecs[6] = '{32'h0000_0001, 32'h0000_5555, 1'b1, 2'b01, 1'b0, 4'b0000, 32'h0,         1'b1};
    vecs[7] = '{32'h0000_0010, 32'hCAFE_F00D, 1'b0, 2'b10, 1'b0, 4'b0000, 32'h0,         1'b0};

    rst_n = 1'b0;
    drive(32'h0, 32'h0, 1'b0, 2'b00);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("reset_ledr", {15'd0, ledr}, 32'd0);
    chk("reset_ledg", {24'd0, ledg}, 32'd0);
    for (int i = 0; i < 8; i++) chk($sformatf("reset_hex%0d", i), {25'd0, hex[i]}, 32'd0);
    chk("reset_lcd", lcd, 32'd0);
    chk("reset_st_err", {31'd0, st_err}, 32'd0);
    chk("reset_err_cnt", {24'd0, err_cnt}, 32'd0);

    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      drive(vecs[i].addr, vecs[i].data, vecs[i].wren, vecs[i].size);
      #1;
      chk($sformatf("v%0d_we", i), {31'd0, dmem_we}, {31'd0, vecs[i].exp_we});
      if (vecs[i].exp_we) begin
        chk($sformatf("v%0d_be", i), {28'd0, dmem_be}, {28'd0, vecs[i].exp_be});
        chk($sformatf("v%0d_wdata", i), dmem_wdata, vecs[i].exp_wdata);
      end
      step();
      if (vecs[i].exp_err) exp_cnt++;
      chk($sformatf("v%0d_st_err", i), {31'd0, st_err}, {31'd0, vecs[i].exp_err});
    end
    chk("table_err_cnt", {24'd0, err_cnt}, exp_cnt);
    chk("dmem_leaves_ledr", {15'd0, ledr}, 32'd0);

    // byte then half merge into the low hex page
    drive(32'h1000_2001, 32'h0000_003F, 1'b1, 2'b00);
    #1 chk("hex_sb_no_dmem", {31'd0, dmem_we}, 32'd0);
    step();
    for (int i = 0; i < 8; i++) chk($sformatf("sb_hex%0d", i), {25'd0, hex[i]}, (i == 1) ? 32'h3F : 32'h0);
    drive(32'h1000_2002, 32'h0000_0679, 1'b1, 2'b01);
    step();
    chk("sh_hex2", {25'd0, hex[2]}, 32'h79);
    chk("sh_hex3", {25'd0, hex[3]}, 32'h06);
    chk("sh_hex1_hold", {25'd0, hex[1]}, 32'h3F);
    drive(32'h1000_2000, 32'h0, 1'b0, 2'b10);
    #1 chk("rdata_hexlo", rdata, 32'h0679_3F00);

    // LEDR word; readback in the store cycle returns the old value
    drive(32'h1000_0000, 32'hFFFF_FFFF, 1'b1, 2'b10);
    #1 chk("rdata_pre_store", rdata, 32'h0);
    step();
    wren = 1'b0;
    #1;
    chk("ledr_word", {15'd0, ledr}, 32'h0001_FFFF);
    chk("rdata_ledr", rdata, 32'hFFFF_FFFF);
    addr = 32'h1000_0004;
    #1 chk("rdata_bad_offset", rdata, 32'h0);
    addr = 32'h0000_0000;
    #1 chk("rdata_dmem", rdata, 32'h0);

    // back-to-back merges into LCD
    drive(32'h1000_4000, 32'h0000_0011, 1'b1, 2'b00);
    step();
    drive(32'h1000_4003, 32'h0000_0044, 1'b1, 2'b00);
    step();
    chk("lcd_b2b", lcd, 32'h4400_0011);

    // three rejects: misaligned, reserved size, unmapped
    drive(32'h1000_0002, 32'h0, 1'b1, 2'b10);
    #1 chk("rej_misal_we", {31'd0, dmem_we}, 32'd0);
    step(); exp_cnt++;
    chk("rej_misal_err", {31'd0, st_err}, 32'd1);
    chk("rej_misal_ledr", {15'd0, ledr}, 32'h0001_FFFF);
    drive(32'h0000_0000, 32'h1234_5678, 1'b1, 2'b11);
    #1 chk("rej_rsvd_we", {31'd0, dmem_we}, 32'd0);
    step(); exp_cnt++;
    chk("rej_rsvd_err", {31'd0, st_err}, 32'd1);
    drive(32'h2000_0000, 32'h1234_5678, 1'b1, 2'b10);
    #1 chk("rej_unmap_we", {31'd0, dmem_we}, 32'd0);
    step(); exp_cnt++;
    chk("rej_unmap_err", {31'd0, st_err}, 32'd1);
    wren = 1'b0;
    step();
    chk("err_pulse_clears", {31'd0, st_err}, 32'd0);
    chk("err_cnt_after_rejects", {24'd0, err_cnt}, exp_cnt);

    // async reset mid-operation drops the in-flight store
    drive(32'h1000_1000, 32'h0000_00A5, 1'b1, 2'b00);
    step();
    chk("ledg_a5", {24'd0, ledg}, 32'hA5);
    drive(32'h1000_1000, 32'h0000_005A, 1'b1, 2'b00);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ledg", {24'd0, ledg}, 32'd0);
    chk("async_ledr", {15'd0, ledr}, 32'd0);
    chk("async_err_cnt", {24'd0, err_cnt}, 32'd0);
    step();
    chk("store_lost", {24'd0, ledg}, 32'd0);
    rst_n = 1'b1;
    wren = 1'b0;
    step();

    // saturation of the reject counter
    drive(32'h0000_0000, 32'h0, 1'b1, 2'b11);
    repeat (300) @(posedge clk);
    #1;
    chk("sat_err_cnt", {24'd0, err_cnt}, 32'd255);
    chk("sat_st_err", {31'd0, st_err}, 32'd1);
    wren = 1'b0;
    step();
    chk("sat_idle_err", {31'd0, st_err}, 32'd0);
    chk("sat_hold", {24'd0, err_cnt}, 32'd255);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
